// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared states, parity encodings and defaults
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD = 2;
    localparam int OVERSAMPLE_DEF = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, m} <= {RST_VAL, RST_VAL};
        else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with start/parity/stop validation
module uart_rx import uart_pkg::*; #(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int PARITY = PAR_NONE,
    parameter int DATA_BITS = 8
) (
    input  logic                 bclk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_dout,
    output logic                 rx_valid,
    output logic                 rx_ferr,
    output logic                 rx_perr,
    output logic                 rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    state_t state;
    logic rxd_s, perr, stop_b, done;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] shreg;
    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(bclk), .rst(rst), .d(rxd), .q(rxd_s));
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
            perr <= 1'b0;
            stop_b <= 1'b0;
            done <= 1'b0;
            rx_dout <= '0;
            rx_valid <= 1'b0;
            rx_ferr <= 1'b0;
            rx_perr <= 1'b0;
            rx_busy <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr <= 1'b0;
            rx_perr <= 1'b0;
            case (state)
                IDLE: if (!rxd_s) begin
                    state <= START;
                    cnt <= '0;
                    perr <= 1'b0;
                    rx_busy <= 1'b1;
                end
                START: if (cnt == HALF) begin
                    cnt <= '0;
                    idx <= '0;
                    state <= rxd_s ? IDLE : DATA;
                    rx_busy <= !rxd_s;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == LAST) begin
                    cnt <= '0;
                    shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                    idx <= idx + 1'b1;
                    if (idx == IW'(DATA_BITS - 1))
                        state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end else cnt <= cnt + 1'b1;
                uart_pkg::PARITY: if (cnt == LAST) begin
                    cnt <= '0;
                    perr <= rxd_s ^ (^shreg) ^ (PARITY == PAR_ODD);
                    state <= STOP;
                end else cnt <= cnt + 1'b1;
                // Flags go out the cycle after the mid-stop sample, freeing IDLE for a gapless next start
                STOP: if (done) begin
                    done <= 1'b0;
                    cnt <= '0;
                    rx_dout <= shreg;
                    rx_valid <= stop_b && !perr;
                    rx_perr <= stop_b && perr;
                    rx_ferr <= !stop_b;
                    rx_busy <= !stop_b;
                    state <= stop_b ? IDLE : BREAK;
                end else if (cnt == LAST) begin
                    stop_b <= rxd_s;
                    done <= 1'b1;
                end else cnt <= cnt + 1'b1;
                BREAK: if (rxd_s) begin
                    state <= IDLE;
                    rx_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the loopback UART; consumes the `txd` line produced by `uart_tx` and recovers bytes.
- Oversamples `rxd` on `bclk`, which runs at OVERSAMPLE × baud.
- Validates start, optional parity and stop bits.
- Presents each byte with a one-cycle valid strobe to downstream logic; the loopback top feeds these bytes back to `uart_tx`.

Parameters:
- OVERSAMPLE, 16, bclk cycles per bit; even, ≥ 4.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- DATA_BITS, 8, payload bits per frame, LSB first.

Ports:
- bclk  in  1  receive clock, OVERSAMPLE × baud.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input, idle high, asynchronous to bclk.
- rx_dout  out  DATA_BITS  last received byte.
- rx_valid  out  1  one-cycle pulse: rx_dout holds a good frame.
- rx_ferr  out  1  one-cycle pulse: stop bit sampled low.
- rx_perr  out  1  one-cycle pulse: parity mismatch (PARITY≠0).
- rx_busy  out  1  high while a frame is being received.

Behaviour:
- Reset (async assert, released synchronously to bclk):
  - synchronizer flops = 1; state = IDLE; counters = 0.
  - rx_dout = 0; rx_valid = rx_ferr = rx_perr = rx_busy = 0.
- Input path: 2-flop synchronizer produces rxd_s; all decisions use rxd_s only.
- Sampling: a bit counter (0..OVERSAMPLE-1) and a bit index (0..DATA_BITS-1) pace sampling.
- States:
  - IDLE:
    - rxd_s==0 → START, counter cleared.
    - rx_busy goes high on the cycle the state leaves IDLE.
  - START:
    - At counter==OVERSAMPLE/2-1 sample rxd_s (mid start bit).
    - Sample 1 → false start → IDLE; no flags.
    - Sample 0 → DATA, counter cleared.
  - DATA:
    - Every OVERSAMPLE cycles (counter==OVERSAMPLE-1), sample rxd_s and shift it in at the MSB of the shift register, so after DATA_BITS samples bit 0 is first-received.
    - After DATA_BITS samples → PARITY if PARITY≠0, else STOP.
  - PARITY:
    - One sample at the next mid-bit point; compare against the XOR of the data bits.
    - Record mismatch internally.
  - STOP:
    - One sample at the next mid-bit point.
    - Next cycle: rx_dout ← shift register (always updated).
    - Next cycle, stop bit = 1: rx_valid = !perr and rx_perr = perr; state → IDLE.
    - Next cycle, stop bit = 0: rx_ferr = 1, rx_valid = 0, rx_perr = 0; state → BREAK.
    - Going to IDLE at mid-stop allows a back-to-back start bit with no gap.
  - BREAK: stay until rxd_s==1, then → IDLE. Covers a line held low or a break condition.
- Latency (PARITY=0), with t0 = first bclk edge that samples rxd low:
  - Mid-bit samples at t0+2+OVERSAMPLE/2+k×OVERSAMPLE, for k = 0 (start), 1..DATA_BITS (data), DATA_BITS+1 (stop).
  - Flags assert one cycle after the stop sample.
  - OVERSAMPLE=16, DATA_BITS=8: rx_valid high exactly at t0+155.
- Strobes: rx_valid, rx_ferr and rx_perr are never high simultaneously; each lasts exactly one cycle.
- rx_busy: low in IDLE, high in START, DATA, PARITY, STOP and BREAK.
- Reset mid-frame: all state is discarded immediately, no strobe is issued, and the receiver resumes hunting in IDLE.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP, BREAK};
  - parity encoding constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - default OVERSAMPLE;
  - shared with uart_tx.
- Sub-module sync_2ff (1-bit, reset value parameter): the rxd synchronizer; reusable elsewhere.

Test Plan:
1. Drive frame 0x0A (start, 0,1,0,1,0,0,0,0, stop) at 16 cycles/bit → rx_valid one-cycle pulse at t0+155; rx_dout=0x0A; rx_ferr=rx_perr=0.
2. Back-to-back 0x55 then 0xAA with no idle gap → two rx_valid pulses exactly 160 cycles apart; rx_dout 0x55 then 0xAA.
3. rxd low for 4 cycles then high → no strobes; rx_busy pulses high then returns low; state back to IDLE.
4. Frame 0xC3 with stop bit low, line held low 40 more cycles → rx_ferr pulse; no rx_valid; rx_busy high until rxd high; next good frame 0x11 received correctly.
5. PARITY=2 (odd), send 0x07 with parity bit 1 → rx_perr pulse, no rx_valid. Same byte with parity bit 0 → rx_valid, rx_dout=0x07.
6. Assert rst during data bit 4 of a frame → outputs 0 immediately. After release, a fresh frame 0x3C yields rx_valid with rx_dout=0x3C and no spurious strobe.
